// File: rtl/md_iter_unit.sv
// rtl/md_iter_unit.sv - iterative RV32M multiply/divide unit for the EX stage
package milano_pkg;
    typedef enum logic [3:0] {
        MD_OP_NONE   = 4'd0,
        MD_OP_MUL    = 4'd1,
        MD_OP_MULH   = 4'd2,
        MD_OP_MULHSU = 4'd3,
        MD_OP_MULHU  = 4'd4,
        MD_OP_DIV    = 4'd5,
        MD_OP_DIVU   = 4'd6,
        MD_OP_REM    = 4'd7,
        MD_OP_REMU   = 4'd8
    } md_opt_e;
endpackage

module md_iter_unit
    import milano_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        refresh_pip_i,
    input  logic        md_sel_i,
    input  md_opt_e     md_operate_i,
    input  logic [31:0] md_operand_a_i,
    input  logic [31:0] md_operand_b_i,
    output logic [31:0] md_result_o,
    output logic        md_valid_o,
    output logic        md_stall_o
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e      state_q, state_d;
    md_opt_e     op_q;
    logic [31:0] a_mag_q, b_mag_q, quot_q, rem_q, result_q;
    logic [63:0] prod_q;
    logic        a_neg_q, neg_q, valid_q;
    logic [5:0]  cnt_q;

    logic        start, is_mul_in, a_neg_in, b_neg_in, div_zero, div_ovf, special;
    logic [31:0] a_mag_in, b_mag_in, special_res;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [63:0] prod_nx, prod_fin;
    logic [31:0] rem_nx, quot_nx, mul_res, div_res;

    // Decode of the incoming instruction, only consumed on the start cycle
    always_comb begin
        start     = md_sel_i && (md_operate_i != MD_OP_NONE) && !refresh_pip_i;
        is_mul_in = (md_operate_i == MD_OP_MUL) || (md_operate_i == MD_OP_MULH) ||
                    (md_operate_i == MD_OP_MULHSU) || (md_operate_i == MD_OP_MULHU);
        a_neg_in  = md_operand_a_i[31] && ((md_operate_i == MD_OP_MULH) ||
                    (md_operate_i == MD_OP_MULHSU) || (md_operate_i == MD_OP_DIV) ||
                    (md_operate_i == MD_OP_REM));
        b_neg_in  = md_operand_b_i[31] && ((md_operate_i == MD_OP_MULH) ||
                    (md_operate_i == MD_OP_DIV) || (md_operate_i == MD_OP_REM));
        a_mag_in  = a_neg_in ? -md_operand_a_i : md_operand_a_i;
        b_mag_in  = b_neg_in ? -md_operand_b_i : md_operand_b_i;
        div_zero  = (md_operand_b_i == 32'd0);
        div_ovf   = ((md_operate_i == MD_OP_DIV) || (md_operate_i == MD_OP_REM)) &&
                    (md_operand_a_i == 32'h8000_0000) && (md_operand_b_i == 32'hFFFF_FFFF);
        special   = !is_mul_in && (div_zero || div_ovf);
        if (div_zero)
            special_res = ((md_operate_i == MD_OP_DIV) || (md_operate_i == MD_OP_DIVU)) ?
                          32'hFFFF_FFFF : md_operand_a_i;
        else
            special_res = (md_operate_i == MD_OP_DIV) ? 32'h8000_0000 : 32'd0;
    end

    // One shift-add step (multiplier in the low half) and one restoring-divide step
    always_comb begin
        mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_mag_q} : 33'd0);
        prod_nx   = {mul_sum, prod_q[31:1]};
        prod_fin  = neg_q ? -prod_nx : prod_nx;
        mul_res   = (op_q == MD_OP_MUL) ? prod_fin[31:0] : prod_fin[63:32];
        div_shift = {rem_q, quot_q[31]};
        div_diff  = div_shift - {1'b0, b_mag_q};
        rem_nx    = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
        quot_nx   = {quot_q[30:0], ~div_diff[32]};
        if ((op_q == MD_OP_REM) || (op_q == MD_OP_REMU))
            div_res = a_neg_q ? -rem_nx : rem_nx;
        else
            div_res = neg_q ? -quot_nx : quot_nx;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        md_stall_o = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                md_stall_o = 1'b1;
                state_d    = is_mul_in ? S_MUL : (special ? S_DONE : S_DIV);
            end
            S_MUL, S_DIV: begin
                md_stall_o = !refresh_pip_i;
                if (cnt_q == 6'd31) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (refresh_pip_i) state_d = S_IDLE;
        if (rst_i) md_stall_o = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= MD_OP_NONE;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            a_neg_q  <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!refresh_pip_i) begin
                case (state_q)
                    S_IDLE: if (start) begin
                        op_q    <= md_operate_i;
                        a_mag_q <= a_mag_in;
                        b_mag_q <= b_mag_in;
                        a_neg_q <= a_neg_in;
                        neg_q   <= a_neg_in ^ b_neg_in;
                        cnt_q   <= '0;
                        prod_q  <= {32'd0, b_mag_in};
                        quot_q  <= a_mag_in;
                        rem_q   <= '0;
                        if (special) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                        end
                    end
                    S_MUL: begin
                        prod_q <= prod_nx;
                        cnt_q  <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            result_q <= mul_res;
                            valid_q  <= 1'b1;
                        end
                    end
                    S_DIV: begin
                        rem_q  <= rem_nx;
                        quot_q <= quot_nx;
                        cnt_q  <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            result_q <= div_res;
                            valid_q  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign md_result_o = result_q;
    assign md_valid_o  = valid_q;
endmodule

// File: tb/tb_md_iter_unit.sv
// tb/tb_md_iter_unit.sv - scoreboard bench for md_iter_unit
module tb_md_iter_unit;
    import milano_pkg::*;

    logic        clk = 1'b0;
    logic        rst, refresh, sel;
    md_opt_e     op;
    logic [31:0] a, b, result;
    logic        valid, stall;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb[$];

    md_iter_unit dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .refresh_pip_i  (refresh),
        .md_sel_i       (sel),
        .md_operate_i   (op),
        .md_operand_a_i (a),
        .md_operand_b_i (b),
        .md_result_o    (result),
        .md_valid_o     (valid),
        .md_stall_o     (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input md_opt_e o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0]        p;
        logic signed [63:0] sp;
        case (o)
            MD_OP_MUL:    begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
            MD_OP_MULH:   begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return sp[63:32]; end
            MD_OP_MULHSU: begin p = {{32{x[31]}}, x} * {32'd0, y}; return p[63:32]; end
            MD_OP_MULHU:  begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
            MD_OP_DIV:    return $signed(x) / $signed(y);
            MD_OP_DIVU:   return x / y;
            MD_OP_REM:    return $signed(x) % $signed(y);
            default:      return x % y;
        endcase
    endfunction

    // Start in C0, expect stall through C(lat-1) and the result strobe in C(lat)
    task automatic run_op(input md_opt_e o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int lat, input string tag);
        @(negedge clk);
        sel = 1'b1; op = o; a = x; b = y;
        sb.push_back(exp);
        #1 chk({tag, " stall C0"}, stall, 1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 5) begin a = $urandom; b = $urandom; end
            #1;
            if (k < lat) begin
                chk({tag, " stall busy"}, stall, 1);
                chk({tag, " early valid"}, valid, 0);
            end else begin
                chk({tag, " stall done"}, stall, 0);
                chk({tag, " valid done"}, valid, 1);
                chk({tag, " sb depth"}, sb.size(), 1);
                if (sb.size() > 0) chk({tag, " result"}, result, sb.pop_front());
            end
        end
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        sel = 1'b0; op = MD_OP_NONE;
        @(negedge clk);
        #1;
        chk({tag, " idle valid"}, valid, 0);
        chk({tag, " idle stall"}, stall, 0);
    endtask

    initial begin
        md_opt_e     ro;
        logic [31:0] ra, rb;

        rst = 1'b1; refresh = 1'b0; sel = 1'b1; op = MD_OP_MUL; a = 32'd1; b = 32'd1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset stall", stall, 0);
        chk("reset valid", valid, 0);
        chk("reset result", result, 0);
        @(negedge clk);
        rst = 1'b0; sel = 1'b0; op = MD_OP_NONE;

        run_op(MD_OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        idle_cycle("mul");
        run_op(MD_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh1");
        run_op(MD_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh2");
        run_op(MD_OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 33, "mulhsu1");
        run_op(MD_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu2");
        run_op(MD_OP_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulhu1");
        run_op(MD_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu2");
        run_op(MD_OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
        run_op(MD_OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
        run_op(MD_OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu");
        run_op(MD_OP_REMU, 32'd100, 32'd7, 32'd2, 33, "remu");
        idle_cycle("div");

        run_op(MD_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu0");
        idle_cycle("divu0");
        run_op(MD_OP_REM, 32'd5, 32'd0, 32'd5, 1, "rem0");
        run_op(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "divovf");
        run_op(MD_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "removf");
        idle_cycle("special");

        @(negedge clk);
        sel = 1'b1; op = MD_OP_DIV; a = 32'd1000; b = 32'd3;
        #1 chk("flush stall C0", stall, 1);
        repeat (10) @(negedge clk);
        refresh = 1'b1;
        #1 chk("flush stall C10", stall, 0);
        @(negedge clk);
        refresh = 1'b0; sel = 1'b0; op = MD_OP_NONE;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            #1 chk("flush no valid", valid, 0);
        end
        run_op(MD_OP_MUL, 32'd3, 32'd4, 32'd12, 33, "mul after flush");
        idle_cycle("flush");

        @(negedge clk);
        sel = 1'b1; op = MD_OP_DIVU; a = 32'hFFFF_FFFF; b = 32'd3;
        #1 chk("rst stall C0", stall, 1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1 chk("rst stall C20", stall, 0);
        @(negedge clk);
        rst = 1'b0; sel = 1'b0; op = MD_OP_NONE;
        #1 chk("rst result cleared", result, 0);
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            #1 chk("rst no valid", valid, 0);
        end
        run_op(MD_OP_MUL, 32'd3, 32'd4, 32'd12, 33, "mul after rst");
        idle_cycle("rst");

        @(negedge clk);
        sel = 1'b1; op = MD_OP_NONE; a = 32'd9; b = 32'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("none stall", stall, 0);
            chk("none valid", valid, 0);
            @(negedge clk);
        end

        run_op(MD_OP_MUL, 32'h0001_0003, 32'h0000_1005, 32'h1005_300F, 33, "b2b mul");
        run_op(MD_OP_DIVU, 32'd1_000_000, 32'd999, 32'd1001, 33, "b2b divu");

        for (int i = 0; i < 6; i++) begin
            ro = md_opt_e'($urandom_range(1, 8));
            ra = $urandom;
            rb = ($urandom & 32'h7FFF_FFFF) | 32'd1;
            run_op(ro, ra, rb, model(ro, ra, rb), 33, "random");
        end
        idle_cycle("random");

        chk("sb drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
